multiplicador_secuencial: RTL and testbench
===========================================

# multiplicador_secuencial

- Iterative signed fixed-point multiplier (shift-add, one partial product per clock) with a start/ready/valid handshake.
- Returns both the full-precision product and a rescaled, saturated N-bit result with an overflow flag.
- Sits in the filter datapath wherever one multiplier is time-shared across samples × coefficients instead of instantiating a combinational N×N array.

## Interface
- N, default 24: operand width, two's complement.
- FRAC, default 10: fractional bits of the operand Q format. Legal range 0 ≤ FRAC ≤ N-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a multiplication; honoured only when listo=1.
- multiplicando  in  N  signed operand A, sampled on the accepting edge only.
- constante  in  N  signed operand B (coefficient), sampled on the accepting edge only.
- listo  out  1  block idle, can accept start.
- valido  out  1  one-cycle pulse: producto, producto_completo and desborde are updated.
- producto_completo  out  2N  signed full product A×B.
- producto  out  N  signed (A×B)>>>FRAC, saturated to N bits.
- desborde  out  1  saturation occurred on the current result.

## Operation
- States: REPOSO, CALCULO, AJUSTE. listo = (state == REPOSO), decoded from the state register.
- REPOSO, start=1 on an edge (the acceptance edge E0):
  - latch |A| and |B| as N-bit unsigned; |−2^(N-1)| = 2^(N-1) fits.
  - latch sign = A[N-1] XOR B[N-1].
  - clear the 2N-bit accumulator and set the bit counter to 0.
  - go to CALCULO.
- CALCULO, one step per edge, N edges total (E1..EN):
  - if the multiplier LSB = 1, add the shifted multiplicand to the accumulator;
  - shift the multiplicand left and the multiplier right; increment the counter.
  - At EN (counter = N-1), go to AJUSTE.
- AJUSTE, single edge E(N+1):
  - producto_completo ← sign ? −acc : acc. The magnitude is ≤ 2^(2N-2), so the result always fits in 2N signed bits.
  - s = producto_completo >>> FRAC. Arithmetic shift, truncation toward −∞.
  - s > 2^(N-1)−1: producto = 2^(N-1)−1, desborde=1.
  - s < −2^(N-1): producto = −2^(N-1), desborde=1.
  - otherwise: producto = s[N-1:0], desborde=0.
  - valido ← 1; go to REPOSO.
- start while listo=0: ignored, no queuing. Operand changes after E0 have no effect.
- Outputs hold their last result until the next AJUSTE. desborde describes only the most recent result.
- Zero operands take the same N+1-edge path (no early termination).

## Timing
- Reset values:
  - state = REPOSO, so listo = 1 during and after reset;
  - valido = 0, desborde = 0, producto = 0, producto_completo = 0;
  - accumulator and counter = 0.
- Latency: valido is high in the cycle following E(N+1), i.e. N+1 edges after the acceptance edge, for exactly one cycle.
- listo drops in the cycle after E0 and returns high in the same cycle valido is high.
- Earliest next acceptance is E(N+2), so back-to-back throughput is one result per N+2 cycles.
- Reset asserted mid-operation: the operation is aborted immediately (asynchronous), no valido is produced, and all outputs return to their reset values.
- start held high continuously restarts on every return to REPOSO, each time using the operands present on that edge.

## Test plan
Bench instance N=8, FRAC=4 (Q3.4), plus one smoke test at defaults.
- A=0x18 (1.5), B=0x20 (2.0), start pulse → valido exactly 9 edges after acceptance; producto_completo=0x0300; producto=0x30 (3.0); desborde=0.
- A=0xF0 (−1.0), B=0x28 (2.5) → producto_completo=0xFD80; producto=0xD8 (−2.5); desborde=0.
- A=0xFF, B=0x01 (−1 LSB × 1 LSB) → producto_completo=0xFFFF; producto=0xFF (truncation toward −∞, not 0x00); desborde=0.
- Saturation:
  - A=0x7F, B=0x7F → producto_completo=0x3F01, producto=0x7F, desborde=1.
  - A=0x80, B=0x80 → producto_completo=0x4000, producto=0x7F, desborde=1.
  - A=0x80, B=0x7F → producto_completo=0xC080, producto=0x80, desborde=1.
- Handshake:
  - second start at edge E3 with different operands → ignored; the result matches the first operand pair.
  - start held high → results at 10-cycle spacing, listo and valido coincident.
- Reset mid-operation: reset pulse at E4 → no valido ever; listo=1 and all outputs 0 after reset; a subsequent start with A=0x10, B=0x10 → producto=0x10 (1.0 × 1.0).
- Default parameters (N=24, FRAC=10): A=−5 raw, B=3000 raw → producto_completo=−15000, producto=−15 (−14.6484 truncated toward −∞); valido 25 edges after acceptance.

Source files
------------

// File: rtl/multiplicador_secuencial.sv
// Iterative signed fixed-point multiplier: one shift-add partial product per clock.
// Delivers the full 2N-bit product plus an N-bit rescaled (>>> FRAC), saturated
// result with an overflow flag, behind a start/listo/valido handshake.
module multiplicador_secuencial #(
    parameter int N    = 24,
    parameter int FRAC = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     multiplicando,
    input  logic [N-1:0]     constante,
    output logic             listo,
    output logic             valido,
    output logic [2*N-1:0]   producto_completo,
    output logic [N-1:0]     producto,
    output logic             desborde
);

    localparam int CW = $clog2(N + 1);

    // Saturation bounds, sign-extended to the full product width
    localparam logic signed [2*N-1:0] MAXV = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] MINV = {{(N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [1:0] {REPOSO, CALCULO, AJUSTE} state_t;

    state_t                r_state;
    logic [2*N-1:0]        r_mcand;   // |A|, shifted left each step
    logic [N-1:0]          r_mplier;  // |B|, shifted right each step
    logic [2*N-1:0]        r_acc;
    logic [CW-1:0]         r_cnt;
    logic                  r_sign;

    logic [N-1:0]          w_abs_a;
    logic [N-1:0]          w_abs_b;
    logic [2*N-1:0]        w_full;
    logic signed [2*N-1:0] w_s;
    logic                  w_sat_hi;
    logic                  w_sat_lo;

    // Magnitudes fit in N unsigned bits, including |-2^(N-1)|
    assign w_abs_a = multiplicando[N-1] ? (~multiplicando + 1'b1) : multiplicando;
    assign w_abs_b = constante[N-1]     ? (~constante + 1'b1)     : constante;

    // Reapply sign, rescale with floor semantics, then range-check
    assign w_full   = r_sign ? ({(2*N){1'b0}} - r_acc) : r_acc;
    assign w_s      = $signed(w_full) >>> FRAC;
    assign w_sat_hi = (w_s > MAXV);
    assign w_sat_lo = (w_s < MINV);

    assign listo = (r_state == REPOSO);

    // Control FSM, datapath and registered result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= REPOSO;
            r_mcand           <= '0;
            r_mplier          <= '0;
            r_acc             <= '0;
            r_cnt             <= '0;
            r_sign            <= 1'b0;
            valido            <= 1'b0;
            desborde          <= 1'b0;
            producto          <= '0;
            producto_completo <= '0;
        end else begin
            valido <= 1'b0;
            case (r_state)
                REPOSO: begin
                    if (start) begin
                        r_mcand  <= {{N{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_sign   <= multiplicando[N-1] ^ constante[N-1];
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= CALCULO;
                    end
                end
                CALCULO: begin
                    if (r_mplier[0])
                        r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1))
                        r_state <= AJUSTE;
                end
                AJUSTE: begin
                    producto_completo <= w_full;
                    if (w_sat_hi) begin
                        producto <= {1'b0, {(N-1){1'b1}}};
                        desborde <= 1'b1;
                    end else if (w_sat_lo) begin
                        producto <= {1'b1, {(N-1){1'b0}}};
                        desborde <= 1'b1;
                    end else begin
                        producto <= w_s[N-1:0];
                        desborde <= 1'b0;
                    end
                    valido  <= 1'b1;
                    r_state <= REPOSO;
                end
                default: r_state <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed bench: N=8/FRAC=4 table of products plus handshake, hold-start and
// mid-operation reset sequences, and one smoke vector at default parameters.
module tb_multiplicador_secuencial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Q3.4 instance
    logic        st8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        listo8, val8, des8;
    logic [15:0] full8;
    logic [7:0]  prod8;

    // Default-parameter instance
    logic        st24 = 1'b0;
    logic [23:0] a24 = '0, b24 = '0;
    logic        listo24, val24, des24;
    logic [47:0] full24;
    logic [23:0] prod24;

    multiplicador_secuencial #(.N(8), .FRAC(4)) dut8 (
        .clk(clk), .reset(rst), .start(st8),
        .multiplicando(a8), .constante(b8),
        .listo(listo8), .valido(val8),
        .producto_completo(full8), .producto(prod8), .desborde(des8)
    );

    multiplicador_secuencial dut24 (
        .clk(clk), .reset(rst), .start(st24),
        .multiplicando(a24), .constante(b24),
        .listo(listo24), .valido(val24),
        .producto_completo(full24), .producto(prod24), .desborde(des24)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One full operation on the N=8 instance, starting just after a clock edge
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] f, output logic [7:0] p,
                        output logic d, output int lat);
        chk("listo_before_start", {63'b0, listo8}, 64'd1);
        a8 = a; b8 = b; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        chk("listo_busy", {63'b0, listo8}, 64'd0);
        lat = 0;
        while (!val8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        f = full8; p = prod8; d = des8;
        if (!val8) chk("valido_timeout", 64'd0, 64'd1);
        chk("listo_with_valido", {63'b0, listo8}, 64'd1);
        @(posedge clk); #1;
        chk("valido_one_cycle", {63'b0, val8}, 64'd0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] full;
        logic [7:0]  prod;
        logic        des;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [15:0] f;
        logic [7:0]  p;
        logic        d;
        int          lat;
        int          cyc;
        int          pulses;
        int          coinc_err;
        logic [47:0] exp_full24;
        logic [23:0] exp_prod24;

        tbl[0] = '{8'h18, 8'h20, 16'h0300, 8'h30, 1'b0};
        tbl[1] = '{8'hF0, 8'h28, 16'hFD80, 8'hD8, 1'b0};
        tbl[2] = '{8'hFF, 8'h01, 16'hFFFF, 8'hFF, 1'b0};
        tbl[3] = '{8'h7F, 8'h7F, 16'h3F01, 8'h7F, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 16'h4000, 8'h7F, 1'b1};
        tbl[5] = '{8'h80, 8'h7F, 16'hC080, 8'h80, 1'b1};
        tbl[6] = '{8'h00, 8'h55, 16'h0000, 8'h00, 1'b0};

        // Reset state, observed while reset is still asserted
        #2;
        chk("rst_listo",  {63'b0, listo8}, 64'd1);
        chk("rst_valido", {63'b0, val8},   64'd0);
        chk("rst_des",    {63'b0, des8},   64'd0);
        chk("rst_prod",   {56'b0, prod8},  64'd0);
        chk("rst_full",   {48'b0, full8},  64'd0);
        chk("rst_listo24", {63'b0, listo24}, 64'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Table of products
        for (int i = 0; i < 7; i++) begin
            run8(tbl[i].a, tbl[i].b, f, p, d, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd9);
            chk($sformatf("v%0d_full", i), {48'b0, f}, {48'b0, tbl[i].full});
            chk($sformatf("v%0d_prod", i), {56'b0, p}, {56'b0, tbl[i].prod});
            chk($sformatf("v%0d_des", i),  {63'b0, d}, {63'b0, tbl[i].des});
        end

        // Second start at E3 with new operands is ignored; operand changes after E0 too
        a8 = 8'h18; b8 = 8'h20; st8 = 1'b1;
        @(posedge clk); #1;            // E0
        st8 = 1'b0; a8 = 8'h55; b8 = 8'h66;
        @(posedge clk); #1;            // E1
        @(posedge clk); #1;            // E2
        a8 = 8'h7F; b8 = 8'h7F; st8 = 1'b1;
        @(posedge clk); #1;            // E3
        st8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat = 3;
        while (!val8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ignore_latency", 64'(lat), 64'd9);
        chk("ignore_full", {48'b0, full8}, 64'h0300);
        chk("ignore_prod", {56'b0, prod8}, 64'h30);
        @(posedge clk); #1;
        chk("ignore_no_second", {63'b0, val8}, 64'd0);
        repeat (12) begin
            @(posedge clk); #1;
            if (val8) chk("ignore_spurious_valido", 64'd1, 64'd0);
        end

        // start held high: results every N+2 cycles, listo tracks valido
        a8 = 8'hF0; b8 = 8'h28; st8 = 1'b1;
        @(posedge clk); #1;            // first acceptance
        cyc = 0; pulses = 0; coinc_err = 0; lat = 0;
        while (pulses < 2 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (listo8 !== val8) coinc_err++;
            if (val8) begin
                pulses++;
                if (pulses == 1) lat = cyc;
                else lat = cyc - lat;
                if (pulses == 2) st8 = 1'b0;
                a8 = 8'h18; b8 = 8'h20;
            end
        end
        chk("hold_pulses", 64'(pulses), 64'd2);
        chk("hold_spacing", 64'(lat), 64'd10);
        chk("hold_listo_eq_valido", 64'(coinc_err), 64'd0);
        chk("hold_second_prod", {56'b0, prod8}, 64'h30);
        @(posedge clk); #1;
        chk("hold_stopped", {63'b0, listo8}, 64'd1);

        // Reset mid-operation: abort, no valido, outputs cleared asynchronously
        a8 = 8'h7F; b8 = 8'h7F; st8 = 1'b1;
        @(posedge clk); #1;            // E0
        st8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end   // E1..E3
        @(negedge clk); rst = 1'b1;
        #1;
        chk("arst_listo", {63'b0, listo8}, 64'd1);
        chk("arst_full",  {48'b0, full8},  64'd0);
        chk("arst_prod",  {56'b0, prod8},  64'd0);
        chk("arst_des",   {63'b0, des8},   64'd0);
        @(posedge clk); #1;            // E4 under reset
        rst = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (val8) pulses++;
        end
        chk("arst_no_valido", 64'(pulses), 64'd0);
        run8(8'h10, 8'h10, f, p, d, lat);
        chk("post_rst_prod", {56'b0, p}, 64'h10);
        chk("post_rst_full", {48'b0, f}, 64'h0100);
        chk("post_rst_des",  {63'b0, d}, 64'd0);

        // Default parameters smoke test
        exp_full24 = -48'sd15000;
        exp_prod24 = -24'sd15;
        a24 = -24'sd5; b24 = 24'd3000; st24 = 1'b1;
        @(posedge clk); #1;
        st24 = 1'b0;
        lat = 0;
        while (!val24 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("def_latency", 64'(lat), 64'd25);
        chk("def_full", {16'b0, full24}, {16'b0, exp_full24});
        chk("def_prod", {40'b0, prod24}, {40'b0, exp_prod24});
        chk("def_des",  {63'b0, des24},  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
